// File: rtl/ksa_swap_loop.sv
// ksa_swap_loop: RC4 key-scheduling swap pass over an external S-RAM (s[k]=k on entry).
// Optional macro KSA_SKIP_IDENTITY_SWAP_EN skips the j read and both writes when j==i.
`default_nettype none

module ksa_swap_loop (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] secret_key,
  input  logic [7:0]  s_ram_q,
  output logic [7:0]  s_address,
  output logic [7:0]  s_data,
  output logic        s_wren,
  output logic        finish
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    REQ_I     = 4'd1,
    WAIT_I1   = 4'd2,
    WAIT_I2   = 4'd3,
    READ_I    = 4'd4,
    COMPUTE_J = 4'd5,
    REQ_J     = 4'd6,
    WAIT_J1   = 4'd7,
    WAIT_J2   = 4'd8,
    READ_J    = 4'd9,
    WRITE_I   = 4'd10,
    WRITE_J   = 4'd11,
    NEXT      = 4'd12,
    DONE      = 4'd13
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] i_q, i_d;
  logic [7:0] j_q, j_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] si_q, si_d;
  logic [7:0] sj_q, sj_d;
  logic [7:0] s_address_q, s_address_d;
  logic [7:0] s_data_q, s_data_d;
  logic       s_wren_q, s_wren_d;
  logic       finish_q, finish_d;
  logic [7:0] key_byte;

  always_comb begin
    case (sel_q)
      2'd0:    key_byte = secret_key[23:16];
      2'd1:    key_byte = secret_key[15:8];
      default: key_byte = secret_key[7:0];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    sel_d       = sel_q;
    si_d        = si_q;
    sj_d        = sj_q;
    s_address_d = s_address_q;
    s_data_d    = s_data_q;
    s_wren_d    = 1'b0;
    case (state_q)
      IDLE: begin
        i_d         = 8'd0;
        j_d         = 8'd0;
        sel_d       = 2'd0;
        s_address_d = 8'd0;
        if (start) state_d = REQ_I;
      end
      REQ_I:   state_d = WAIT_I1;
      WAIT_I1: state_d = WAIT_I2;
      WAIT_I2: state_d = READ_I;
      READ_I: begin
        si_d    = s_ram_q;
        state_d = COMPUTE_J;
      end
      // Address is loaded with the new j so REQ_J presents it on the bus.
      COMPUTE_J: begin
        j_d         = j_q + si_q + key_byte;
        s_address_d = j_d;
        state_d     = REQ_J;
      end
      REQ_J: begin
`ifdef KSA_SKIP_IDENTITY_SWAP_EN
        if (j_q == i_q) state_d = NEXT;
        else            state_d = WAIT_J1;
`else
        state_d = WAIT_J1;
`endif
      end
      WAIT_J1: state_d = WAIT_J2;
      WAIT_J2: state_d = READ_J;
      // s[j] goes straight to the write-data register for the s[i] write.
      READ_J: begin
        sj_d        = s_ram_q;
        s_address_d = i_q;
        s_data_d    = s_ram_q;
        s_wren_d    = 1'b1;
        state_d     = WRITE_I;
      end
      WRITE_I: begin
        s_address_d = j_q;
        s_data_d    = si_q;
        s_wren_d    = 1'b1;
        state_d     = WRITE_J;
      end
      WRITE_J: state_d = NEXT;
      NEXT: begin
        if (i_q == 8'd255) begin
          state_d = DONE;
        end else begin
          i_d         = i_q + 8'd1;
          sel_d       = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
          s_address_d = i_d;
          state_d     = REQ_I;
        end
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    finish_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      i_q         <= 8'd0;
      j_q         <= 8'd0;
      sel_q       <= 2'd0;
      si_q        <= 8'd0;
      sj_q        <= 8'd0;
      s_address_q <= 8'd0;
      s_data_q    <= 8'd0;
      s_wren_q    <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      sel_q       <= sel_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      s_address_q <= s_address_d;
      s_data_q    <= s_data_d;
      s_wren_q    <= s_wren_d;
      finish_q    <= finish_d;
    end
  end

  assign s_address = s_address_q;
  assign s_data    = s_data_q;
  assign s_wren    = s_wren_q;
  assign finish    = finish_q;

endmodule

`default_nettype wire

// File: tb/tb_ksa_swap_loop.sv
// tb_ksa_swap_loop: directed + randomized key-scheduling passes against a software KSA model.
`default_nettype none

module tb_ksa_swap_loop;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [23:0] secret_key;
  logic [7:0]  s_ram_q;
  logic [7:0]  s_address;
  logic [7:0]  s_data;
  logic        s_wren;
  logic        finish;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  ksa_swap_loop dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .secret_key (secret_key),
    .s_ram_q    (s_ram_q),
    .s_address  (s_address),
    .s_data     (s_data),
    .s_wren     (s_wren),
    .finish     (finish)
  );

  // S-RAM with 2-cycle read latency; also logs every committed write.
  logic [7:0]  mem [256];
  logic [7:0]  pipe_q;
  logic        init_req = 1'b0;
  int          wr_cnt = 0;
  int          bad_addr = 0;
  logic [15:0] wr_log [$];

  always @(posedge clk) begin
    if (init_req) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (s_wren) begin
      mem[s_address] <= s_data;
    end
    pipe_q  <= mem[s_address];
    s_ram_q <= pipe_q;
    if (s_wren) begin
      wr_cnt = wr_cnt + 1;
      wr_log.push_back({s_address, s_data});
      if ($isunknown({s_address, s_data})) bad_addr = bad_addr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ksa_model(input logic [23:0] key, output logic [7:0] s [256]);
    int j;
    int kb;
    logic [7:0] t;
    for (int k = 0; k < 256; k++) s[k] = 8'(k);
    j = 0;
    for (int i = 0; i < 256; i++) begin
      case (i % 3)
        0:       kb = int'(key[23:16]);
        1:       kb = int'(key[15:8]);
        default: kb = int'(key[7:0]);
      endcase
      j = (j + int'(s[i]) + kb) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
  endtask

  task automatic check_ram(input string tag, input logic [23:0] key);
    logic [7:0] ref_s [256];
    int bad;
    int first;
    ksa_model(key, ref_s);
    bad = 0;
    first = -1;
    for (int k = 0; k < 256; k++) begin
      if (mem[k] !== ref_s[k]) begin
        bad++;
        if (first < 0) first = k;
      end
    end
    if (bad != 0) $display("  %s: first differing byte %0d dut=%0h model=%0h", tag, first, mem[first], ref_s[first]);
    chk(tag, 32'(bad), 32'd0);
  endtask

  task automatic init_ram();
    @(negedge clk) init_req = 1'b1;
    @(negedge clk) init_req = 1'b0;
  endtask

  // lat counts edges after the one that samples start until finish is seen high.
  task automatic run_pass(input logic [23:0] key, input bit hold, output int lat);
    @(negedge clk);
    secret_key = key;
    start = 1'b1;
    @(posedge clk);
    lat = 0;
    while (lat < 4000) begin
      @(posedge clk);
      lat++;
      #1;
      if (finish) break;
    end
    if (!hold) begin
      @(negedge clk) start = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;
    int w0;
    int c0;
    logic [23:0] key;

    reset = 1'b1;
    start = 1'b0;
    secret_key = 24'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wren", 32'(s_wren), 32'd0);
    chk("reset_finish", 32'(finish), 32'd0);
    chk("reset_addr", 32'(s_address), 32'd0);
    chk("reset_data", 32'(s_data), 32'd0);
    @(negedge clk) reset = 1'b0;

    // Directed key 010203: first swap is s[0]<->s[1].
    init_ram();
    w0 = wr_log.size();
    run_pass(24'h010203, 1'b0, lat);
    chk("k010203_latency", 32'(lat), 32'd3072);
    chk("k010203_wr0", (wr_log.size() > w0) ? 32'(wr_log[w0]) : 32'hdead, 32'h0001);
    chk("k010203_wr1", (wr_log.size() > w0 + 1) ? 32'(wr_log[w0+1]) : 32'hdead, 32'h0100);
    check_ram("k010203_ram", 24'h010203);

    // Zero key: fixed latency and write count.
    init_ram();
    c0 = wr_cnt;
    run_pass(24'h000000, 1'b0, lat);
    chk("k0_latency", 32'(lat), 32'd3072);
    chk("k0_writes", 32'(wr_cnt - c0), 32'd512);
    check_ram("k0_ram", 24'h000000);

    for (int r = 0; r < 3; r++) begin
      key = 24'($urandom);
      init_ram();
      c0 = wr_cnt;
      run_pass(key, 1'b0, lat);
      chk($sformatf("rand%0d_writes", r), 32'(wr_cnt - c0), 32'd512);
      check_ram($sformatf("rand%0d_ram_key%06h", r, key), key);
    end

    // Reset in the middle of a pass, then a clean rerun.
    init_ram();
    @(negedge clk);
    secret_key = 24'h5A3C0F;
    start = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset_wren", 32'(s_wren), 32'd0);
    chk("midreset_finish", 32'(finish), 32'd0);
    c0 = wr_cnt;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset_nowrites", 32'(wr_cnt - c0), 32'd0);
    reset = 1'b0;
    init_ram();
    run_pass(24'h5A3C0F, 1'b0, lat);
    chk("after_reset_latency", 32'(lat), 32'd3072);
    check_ram("after_reset_ram", 24'h5A3C0F);

    // Start held high after completion.
    init_ram();
    run_pass(24'h123456, 1'b1, lat);
    c0 = wr_cnt;
    repeat (20) @(negedge clk);
    chk("hold_finish", 32'(finish), 32'd1);
    chk("hold_nowrites", 32'(wr_cnt - c0), 32'd0);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("release_finish", 32'(finish), 32'd0);
    init_ram();
    run_pass(24'h4A6B2C, 1'b0, lat);
    check_ram("second_start_ram", 24'h4A6B2C);

    // All-ones key drives j around the wrap repeatedly.
    init_ram();
    run_pass(24'hFFFFFF, 1'b0, lat);
    chk("kFF_latency", 32'(lat), 32'd3072);
    check_ram("kFF_ram", 24'hFFFFFF);
    chk("addr_known", 32'(bad_addr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
